// File: rtl/uart_rx_pair_pkg.sv
// rtl/uart_rx_pair_pkg.sv - shared state encoding and defaults for the paired-byte UART receiver
package uart_rx_pair_pkg;

  localparam int DEFAULT_CLOCKS_POR_BIT = 5209;
  localparam int CNT_W                  = 13;

  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    BIT_INICIO = 3'd1,
    BITS       = 3'd2,
    BIT_FINAL  = 3'd3,
    LIMPEZA    = 3'd4
  } estado_t;

endpackage

// File: rtl/uart_rx_pair_sincronizador_bit.sv
// rtl/uart_rx_pair_sincronizador_bit.sv - two-flop synchronizer for the serial line, resets to idle-high
module sincronizador_bit (
  input  logic clock,
  input  logic resetN,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx_pair.sv
// rtl/uart_rx_pair.sv - 8N1 receiver publishing bytes in pairs; UART_RX_TIMEOUT_EN drops a stale half pair
module uart_rx_pair
  import uart_rx_pair_pkg::*;
#(
  parameter int CLOCKS_POR_BIT = DEFAULT_CLOCKS_POR_BIT,
  parameter int TIMEOUT_BITS   = 20
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       bitSerialRecebido,
  output logic [7:0] primeiroByteRecebido,
  output logic [7:0] segundoByteRecebido,
  output logic       parRecebido,
  output logic       erroDeQuadro,
  output logic       indicaRecepcao,
  output logic       erroTimeout
);

  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(CLOCKS_POR_BIT - 1);
  localparam logic [CNT_W-1:0] MEIO   = CNT_W'((CLOCKS_POR_BIT - 1) / 2);

  logic             rx_s;
  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       dado_q, dado_d;
  logic [7:0]       retido_q, retido_d;
  logic             flag_q, flag_d;
  logic [7:0]       primeiro_q, primeiro_d;
  logic [7:0]       segundo_q, segundo_d;
  logic             par_q, par_d;
  logic             erro_q, erro_d;
  logic             inicio_det;
  logic             tmo_hit;

  sincronizador_bit u_sinc (
    .clock    (clock),
    .resetN   (resetN),
    .async_in (bitSerialRecebido),
    .sync_out (rx_s)
  );

  assign inicio_det = (estado_q == ESPERA) && !rx_s;

`ifdef UART_RX_TIMEOUT_EN
  localparam logic [7:0] TMO_ULTIMO = 8'(TIMEOUT_BITS - 1);

  logic [CNT_W-1:0] tclk_q, tclk_d;
  logic [7:0]       tbits_q, tbits_d;
  logic             tmo_q;

  // Bit periods spent idle while a first byte waits for its partner.
  always_comb begin
    tclk_d  = tclk_q;
    tbits_d = tbits_q;
    tmo_hit = 1'b0;
    if (!flag_q || inicio_det) begin
      tclk_d  = '0;
      tbits_d = '0;
    end else if (estado_q == ESPERA) begin
      if (tclk_q == ULTIMO) begin
        tclk_d = '0;
        if (tbits_q == TMO_ULTIMO) begin
          tmo_hit = 1'b1;
          tbits_d = '0;
        end else begin
          tbits_d = tbits_q + 8'd1;
        end
      end else begin
        tclk_d = tclk_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      tclk_q  <= '0;
      tbits_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tclk_q  <= tclk_d;
      tbits_q <= tbits_d;
      tmo_q   <= tmo_hit;
    end
  end

  assign erroTimeout = tmo_q;
`else
  localparam int unused_timeout_bits = TIMEOUT_BITS;

  assign tmo_hit     = 1'b0;
  assign erroTimeout = 1'b0;
`endif

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    dado_d     = dado_q;
    retido_d   = retido_q;
    flag_d     = flag_q;
    primeiro_d = primeiro_q;
    segundo_d  = segundo_q;
    par_d      = 1'b0;
    erro_d     = 1'b0;
    unique case (estado_q)
      ESPERA: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) estado_d = BIT_INICIO;
      end
      BIT_INICIO: begin
        if (cnt_q == MEIO) begin
          cnt_d    = '0;
          estado_d = rx_s ? ESPERA : BITS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BITS: begin
        if (cnt_q == ULTIMO) begin
          cnt_d  = '0;
          dado_d = {rx_s, dado_q[7:1]};
          if (idx_q == 3'd7) estado_d = BIT_FINAL;
          else               idx_d    = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BIT_FINAL: begin
        if (cnt_q == ULTIMO) begin
          cnt_d    = '0;
          estado_d = LIMPEZA;
          if (!rx_s) begin
            erro_d = 1'b1;
            flag_d = 1'b0;
          end else if (flag_q) begin
            primeiro_d = retido_q;
            segundo_d  = dado_q;
            par_d      = 1'b1;
            flag_d     = 1'b0;
          end else begin
            retido_d = dado_q;
            flag_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LIMPEZA: estado_d = ESPERA;
      default: estado_d = ESPERA;
    endcase
    if (tmo_hit) flag_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      estado_q   <= ESPERA;
      cnt_q      <= '0;
      idx_q      <= '0;
      dado_q     <= '0;
      retido_q   <= '0;
      flag_q     <= 1'b0;
      primeiro_q <= '0;
      segundo_q  <= '0;
      par_q      <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dado_q     <= dado_d;
      retido_q   <= retido_d;
      flag_q     <= flag_d;
      primeiro_q <= primeiro_d;
      segundo_q  <= segundo_d;
      par_q      <= par_d;
      erro_q     <= erro_d;
    end
  end

  assign primeiroByteRecebido = primeiro_q;
  assign segundoByteRecebido  = segundo_q;
  assign parRecebido          = par_q;
  assign erroDeQuadro         = erro_q;
  assign indicaRecepcao       = (estado_q == BIT_INICIO) || (estado_q == BITS) || (estado_q == BIT_FINAL);

endmodule

// File: tb/tb_uart_rx_pair.sv
// tb/tb_uart_rx_pair.sv - self-checking bench for uart_rx_pair (CLOCKS_POR_BIT=16, TIMEOUT_BITS=4)
module tb_uart_rx_pair;
  import uart_rx_pair_pkg::*;

  localparam int CPB = 16;
`ifdef UART_RX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] primeiro, segundo;
  logic       par, erro_q, indica, tmo;

  uart_rx_pair #(.CLOCKS_POR_BIT(CPB), .TIMEOUT_BITS(4)) dut (
    .clock                (clock),
    .resetN               (resetN),
    .bitSerialRecebido    (rx),
    .primeiroByteRecebido (primeiro),
    .segundoByteRecebido  (segundo),
    .parRecebido          (par),
    .erroDeQuadro         (erro_q),
    .indicaRecepcao       (indica),
    .erroTimeout          (tmo)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [15:0] pair_log[$];
  int          run_log[$];
  int          ferr_total = 0;
  int          tmo_total = 0;
  int          run_cur = 0;

  always @(negedge clock) begin
    if (par) pair_log.push_back({primeiro, segundo});
    if (erro_q) ferr_total++;
    if (tmo) tmo_total++;
    if (indica) run_cur++;
    else if (run_cur != 0) begin
      run_log.push_back(run_cur);
      run_cur = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    rx = 1'b1;
    resetN = 1'b0;
    repeat (3) @(negedge clock);
    resetN = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap_bits);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clock);
    idle(gap_bits * CPB);
  endtask

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          gap;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[5];
  int          p0, f0, t0, r0, maxrun, held, exp_ferr, exp_tmo;
  logic [7:0]  hb;
  logic [15:0] exp_pairs[$];
  logic [7:0]  fb[24];
  logic        fok[24];
  int          fgap[24];
  int          gap_choices[4];

  initial begin
    // Reset state
    resetN = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_primeiro", {24'd0, primeiro}, 32'd0);
    chk("rst_segundo", {24'd0, segundo}, 32'd0);
    chk("rst_par", {31'd0, par}, 32'd0);
    chk("rst_erro", {31'd0, erro_q}, 32'd0);
    chk("rst_indica", {31'd0, indica}, 32'd0);
    chk("rst_tmo", {31'd0, tmo}, 32'd0);
    chk("rst_state", {29'd0, dut.estado_q}, {29'd0, ESPERA});
    do_reset();

    // Back-to-back and short-gap pairs
    vecs[0] = '{8'h4F, 8'h55, 0, 16'h4F55};
    vecs[1] = '{8'h00, 8'hFF, 1, 16'h00FF};
    vecs[2] = '{8'hA5, 8'h5A, 2, 16'hA55A};
    vecs[3] = '{8'h80, 8'h01, 0, 16'h8001};
    vecs[4] = '{8'hFF, 8'h00, 1, 16'hFF00};
    for (int v = 0; v < 5; v++) begin
      p0 = pair_log.size();
      send_frame(vecs[v].b0, 1'b1, vecs[v].gap);
      send_frame(vecs[v].b1, 1'b1, 0);
      idle(20);
      chk($sformatf("vec%0d_npairs", v), pair_log.size() - p0, 1);
      chk($sformatf("vec%0d_pulse_bytes", v), {16'd0, pair_log[pair_log.size()-1]}, {16'd0, vecs[v].exp});
      chk($sformatf("vec%0d_outputs", v), {16'd0, primeiro, segundo}, {16'd0, vecs[v].exp});
    end

    // Short low glitch on an idle line
    do_reset();
    p0 = pair_log.size(); f0 = ferr_total; t0 = tmo_total; r0 = run_log.size();
    rx = 1'b0;
    repeat (5) @(negedge clock);
    idle(40);
    maxrun = 0;
    for (int i = r0; i < run_log.size(); i++) if (run_log[i] > maxrun) maxrun = run_log[i];
    chk("glitch_no_pair", pair_log.size() - p0, 0);
    chk("glitch_no_ferr", ferr_total - f0, 0);
    chk("glitch_no_tmo", tmo_total - t0, 0);
    chk("glitch_state", {29'd0, dut.estado_q}, {29'd0, ESPERA});
    chk("glitch_indica_le8", {31'd0, maxrun <= 8}, 32'd1);

    // Framing error followed by a clean pair
    do_reset();
    p0 = pair_log.size(); f0 = ferr_total;
    send_frame(8'hAA, 1'b0, 2);
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    idle(20);
    chk("ferr_count", ferr_total - f0, 1);
    chk("ferr_npairs", pair_log.size() - p0, 1);
    chk("ferr_pair", {16'd0, primeiro, segundo}, 32'h1122);

    // Half pair left idle for 5 bit periods
    do_reset();
    p0 = pair_log.size(); t0 = tmo_total;
    send_frame(8'h33, 1'b1, 5);
    send_frame(8'h44, 1'b1, 0);
    idle(20);
    chk("tmo_count", tmo_total - t0, TMO_EN ? 1 : 0);
    chk("tmo_npairs", pair_log.size() - p0, TMO_EN ? 0 : 1);
    chk("tmo_outputs", {16'd0, primeiro, segundo}, TMO_EN ? 32'h0 : 32'h3344);

    // Reset during bit 3 of the second byte
    do_reset();
    send_frame(8'hC3, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    idle(20);
    chk("mid_pre_pair", {16'd0, primeiro, segundo}, 32'hC33C);
    f0 = ferr_total;
    send_frame(8'h01, 1'b1, 0);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clock);
    end
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clock);
    resetN = 1'b0;
    @(posedge clock);
    #1;
    chk("mid_rst_outputs", {13'd0, primeiro, segundo, par, erro_q, indica}, 32'd0);
    chk("mid_rst_tmo", {31'd0, tmo}, 32'd0);
    @(negedge clock);
    resetN = 1'b1;
    idle(3 * CPB);
    chk("mid_rst_no_ferr", ferr_total - f0, 0);
    p0 = pair_log.size();
    send_frame(8'h01, 1'b1, 0);
    send_frame(8'h80, 1'b1, 0);
    idle(20);
    chk("mid_after_npairs", pair_log.size() - p0, 1);
    chk("mid_after_pair", {16'd0, primeiro, segundo}, 32'h0180);

    // Random frame stream against a pairing model
    do_reset();
    gap_choices[0] = 0; gap_choices[1] = 1; gap_choices[2] = 6; gap_choices[3] = 7;
    for (int i = 0; i < 24; i++) begin
      fb[i]   = 8'($urandom);
      fok[i]  = ($urandom_range(0, 99) >= 15);
      fgap[i] = gap_choices[$urandom_range(0, 3)];
      if (!fok[i] && fgap[i] == 0) fgap[i] = 1;
    end
    held = 0; hb = 8'h00; exp_ferr = 0; exp_tmo = 0;
    exp_pairs.delete();
    for (int i = 0; i < 24; i++) begin
      if (i > 0 && TMO_EN && held != 0 && fgap[i-1] >= 6) begin
        exp_tmo++;
        held = 0;
      end
      if (!fok[i]) begin
        exp_ferr++;
        held = 0;
      end else if (held != 0) begin
        exp_pairs.push_back({hb, fb[i]});
        held = 0;
      end else begin
        hb = fb[i];
        held = 1;
      end
    end
    if (TMO_EN && held != 0) exp_tmo++;
    p0 = pair_log.size(); f0 = ferr_total; t0 = tmo_total;
    for (int i = 0; i < 24; i++) send_frame(fb[i], fok[i], fgap[i]);
    idle(8 * CPB);
    chk("rand_npairs", pair_log.size() - p0, exp_pairs.size());
    for (int i = 0; i < exp_pairs.size(); i++)
      if (p0 + i < pair_log.size())
        chk($sformatf("rand_pair%0d", i), {16'd0, pair_log[p0+i]}, {16'd0, exp_pairs[i]});
    chk("rand_ferr", ferr_total - f0, exp_ferr);
    chk("rand_tmo", tmo_total - t0, exp_tmo);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_pair.md
UART_RX_PAIR -- requirements
Module: uart_rx_pair

Interface
REQ-001 SHALL have parameter CLOCKS_POR_BIT, default 5209, the system clocks per serial bit; legal range 4..8191.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 20, the inter-byte timeout in bit periods; legal range 1..255.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port resetN, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port bitSerialRecebido, input, 1 bit: asynchronous serial line, idle high, 8N1 LSB-first.
REQ-006 SHALL have port primeiroByteRecebido, output, 8 bits: first byte of the last completed pair.
REQ-007 SHALL have port segundoByteRecebido, output, 8 bits: second byte of the last completed pair.
REQ-008 SHALL have port parRecebido, output, 1 bit: one-cycle pulse when both byte outputs update.
REQ-009 SHALL have port erroDeQuadro, output, 1 bit: one-cycle pulse on stop-bit error.
REQ-010 SHALL have port indicaRecepcao, output, 1 bit: high from start-bit detection until the stop-bit decision.
REQ-011 SHALL have port erroTimeout, output, 1 bit: one-cycle pulse when a half pair is discarded.

Function
REQ-012 SHALL pass bitSerialRecebido through a 2-flop synchronizer before use; its added latency is 2 cycles.
REQ-013 SHALL implement states ESPERA, BIT_INICIO, BITS, BIT_FINAL, LIMPEZA; undefined encodings go to ESPERA.
REQ-014 In ESPERA, SHALL clear the clock counter and bit index, and on a synchronized low SHALL go to BIT_INICIO.
REQ-015 In BIT_INICIO, SHALL sample at count (CLOCKS_POR_BIT-1)/2; if low, clear the counter and go to BITS; if high (glitch), return to ESPERA with no pulse.
REQ-016 In BITS, SHALL sample every CLOCKS_POR_BIT cycles from the start-bit midpoint into bit index 0..7, LSB first; after index 7, go to BIT_FINAL.
REQ-017 In BIT_FINAL, SHALL sample once after CLOCKS_POR_BIT cycles; low asserts erroDeQuadro, discards the byte and clears the first-byte-held flag.
REQ-018 In LIMPEZA, SHALL stay exactly one cycle, then go to ESPERA; indicaRecepcao low there.
REQ-019 A valid byte with first-byte-held flag clear SHALL be stored internally and set the flag; outputs are not updated.
REQ-020 A valid byte with the flag set SHALL update both byte outputs, pulse parRecebido in the same cycle, and clear the flag.
REQ-021 parRecebido SHALL assert in the cycle after the stop-bit sample, i.e. during LIMPEZA.
REQ-022 Byte outputs SHALL hold their value between pairs; they never show a half pair.
REQ-023 The clock counter SHALL be 13 bits and SHALL never wrap: it resets at every bit boundary.
REQ-024 A start edge arriving during LIMPEZA SHALL be detected in the following ESPERA cycle with no lost bit.

Reset
REQ-025 With resetN low at a clock edge, SHALL force ESPERA and clear counter, index, flag and timeout counter.
REQ-026 Under that reset, SHALL set all outputs to 0 and set the synchronizer flops to 1.
REQ-027 Reset mid-frame SHALL abort the frame silently, with no error pulse.

Configuration
REQ-028 With macro UART_RX_TIMEOUT_EN defined, SHALL count bit periods while the flag is set and in ESPERA.
REQ-029 When that count reaches TIMEOUT_BITS, SHALL clear the flag and pulse erroTimeout.
REQ-030 A start-bit detection SHALL reset the timeout count.
REQ-031 With the macro undefined, erroTimeout SHALL be tied to 0, no timeout counter SHALL exist, and a held first byte waits indefinitely.

Structure
REQ-032 A shared package SHALL hold the state encodings (3-bit, values 0..4) and the default CLOCKS_POR_BIT 5209.
REQ-033 The 2-flop synchronizer SHALL be sub-module sincronizador_bit; all else inline.

Verification (bench uses CLOCKS_POR_BIT=16, TIMEOUT_BITS=4)
REQ-034 Send 0x4F then 0x55, back-to-back: one parRecebido pulse, primeiroByteRecebido=0x4F, segundoByteRecebido=0x55.
REQ-035 Drive a 5-cycle low glitch on an idle line: no pulses, state back to ESPERA, indicaRecepcao high for at most 8 cycles.
REQ-036 Send 0xAA with stop bit low, then 0x11 and 0x22: erroDeQuadro pulses once, then the pair outputs 0x11/0x22.
REQ-037 With macro defined, send 0x33 and idle 5 bit periods, then send 0x44: erroTimeout pulses and no pair is output; with macro undefined, the pair 0x33/0x44 is output.
REQ-038 Assert resetN low during bit 3 of the second byte: all outputs 0 next cycle; a new pair 0x01/0x80 is received correctly afterwards.
